enthdr_tgt: RTL and testbench
=============================

Name: enthdr_tgt

Overview:
- Target-side responder for the ENTHDR CCC sequence issued by the controller engine.
- Deserializes the broadcast address byte after START/Sr and ACKs 7E+W by pulling SDA low, then receives the CCC byte and its T bit.
- On a valid ENTHDR0 with correct parity, it switches the target into HDR-DDR mode and holds it until the HDR exit detector releases it.
- Sits between the target SCL edge detector / START-STOP detector and the target SDR/HDR mode mux.

Parameters:
- BCAST_ADDR, 7'h7E, broadcast address that is ACKed.
- ENTHDR_CODE, 8'h20, CCC code that enters HDR-DDR (ENTHDR0).

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_engine_en  input  1  block enable; low forces IDLE and releases SDA
- i_scl_pos_edge  input  1  one-cycle pulse on SCL rise (SDA sample point)
- i_scl_neg_edge  input  1  one-cycle pulse on SCL fall (SDA drive-change point)
- i_sda  input  1  synchronized SDA line
- i_start_det  input  1  pulse on START or repeated START
- i_stop_det  input  1  pulse on STOP
- i_hdr_exit  input  1  pulse from the HDR exit pattern detector
- o_sda_low  output  1  open-drain pull-down request (ACK)
- o_hdr_ddr_mode  output  1  level: target is in HDR-DDR
- o_ccc_valid  output  1  one-cycle pulse: non-ENTHDR broadcast CCC received with good parity
- o_ccc_code  output  8  last received CCC byte, valid with o_ccc_valid and held
- o_parity_err  output  1  one-cycle pulse: T bit mismatch
- o_done  output  1  one-cycle pulse on HDR-DDR entry

Behaviour:
- Interface decision: one clock `i_clk`; reset `i_rst_n` is asynchronous and active-low.
- Reset values:
  - All outputs are 0.
  - State is IDLE, bit counter is 0, shift register is 0.
- Data framing:
  - SDA is sampled only on `i_scl_pos_edge`, MSB first, into an 8-bit shift register.
  - A 4-bit counter counts bits 0..8.
- IDLE:
  - `o_sda_low` is 0.
  - `i_start_det` with `i_engine_en` high -> ADDR, counter cleared.
- ADDR:
  - Sample 8 bits.
  - After the 8th sample, if byte == {BCAST_ADDR,1'b0} (8'hFC) -> ACK_WAIT.
  - Otherwise -> IGNORE. No ACK is driven, so the controller sees NACK.
- ACK_WAIT:
  - On the next `i_scl_neg_edge`, set `o_sda_low` = 1 -> ACK.
- ACK:
  - `o_sda_low` stays 1 through the ACK SCL high phase.
  - On the following `i_scl_neg_edge`, clear `o_sda_low` and clear the counter -> CCC.
- CCC:
  - Sample 8 bits, then the 9th sample is the T bit -> EVAL.
- EVAL (1 cycle):
  - Expected T is odd parity: expected T = ~^ccc_byte.
  - T mismatch: pulse `o_parity_err` -> IGNORE.
  - T ok and byte == ENTHDR_CODE: set `o_hdr_ddr_mode`, pulse `o_done` -> HDR.
  - T ok and any other code: load `o_ccc_code`, pulse `o_ccc_valid` -> IGNORE.
  - Latency: outputs assert 1 clock after the T-bit sample cycle.
- IGNORE:
  - `o_sda_low` is 0.
  - `i_stop_det` -> IDLE.
  - `i_start_det` -> ADDR.
- HDR:
  - `o_hdr_ddr_mode` is held at 1.
  - `i_start_det` and `i_stop_det` are ignored, since SDR framing does not apply in HDR.
  - `i_hdr_exit` -> clear `o_hdr_ddr_mode` -> IDLE.
- Priority in any SDR state (ADDR..IGNORE):
  - `i_stop_det` beats `i_start_det`, which beats edge processing.
  - `i_stop_det` -> IDLE with `o_sda_low` released the same cycle.
  - `i_start_det` -> ADDR with counter cleared, i.e. a repeated START restarts framing mid-byte.
- `i_engine_en` low in any state:
  - Next cycle -> IDLE; `o_sda_low` and `o_hdr_ddr_mode` are cleared.
  - No `o_done`, `o_ccc_valid` or `o_parity_err` pulse is generated.
- Simultaneous `i_scl_pos_edge` and `i_scl_neg_edge` in one cycle is illegal and is not handled.
- `o_ccc_code` is updated only on the `o_ccc_valid` pulse.
- Asynchronous reset mid-ACK releases SDA immediately.

Test Plan:
- START, 8'hFC, T-bit phase with CCC 8'h20 and T=0 -> `o_sda_low` high for exactly one SCL period after the 8th bit falling edge; `o_done` one pulse; `o_hdr_ddr_mode`=1 until `i_hdr_exit`, then 0 and IDLE.
- START, 8'hFC, CCC 8'h20 with T=1 -> `o_parity_err` one pulse; `o_hdr_ddr_mode` stays 0; next START + 8'hFC is ACKed again.
- START, address 8'hA4 -> no `o_sda_low` assertion; CCC-phase bits ignored; `i_stop_det` returns to IDLE.
- START, 8'hFC, CCC 8'h06 with T=1 (parity ok) -> `o_ccc_valid` pulse, `o_ccc_code`=8'h06; no HDR entry.
- START, 8'hFC, `i_start_det` after 4 CCC bits, then full 8'hFC + 8'h20/T=0 -> second sequence ACKed and HDR entered.
- `i_stop_det` during ACK -> `o_sda_low` drops the next cycle; `i_engine_en`=0 while in HDR -> `o_hdr_ddr_mode` clears in 1 cycle with no pulses.

Source files
------------

// File: rtl/enthdr_tgt_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// enthdr_tgt_if : SCL/SDA event and result bundle for the ENTHDR target
// Rev 1.0
// ---------------------------------------------------------------------------
interface enthdr_tgt_if;
  logic       i_engine_en;
  logic       i_scl_pos_edge;
  logic       i_scl_neg_edge;
  logic       i_sda;
  logic       i_start_det;
  logic       i_stop_det;
  logic       i_hdr_exit;
  logic       o_sda_low;
  logic       o_hdr_ddr_mode;
  logic       o_ccc_valid;
  logic [7:0] o_ccc_code;
  logic       o_parity_err;
  logic       o_done;

  modport master (
    output i_engine_en, i_scl_pos_edge, i_scl_neg_edge, i_sda,
           i_start_det, i_stop_det, i_hdr_exit,
    input  o_sda_low, o_hdr_ddr_mode, o_ccc_valid, o_ccc_code,
           o_parity_err, o_done
  );

  modport slave (
    input  i_engine_en, i_scl_pos_edge, i_scl_neg_edge, i_sda,
           i_start_det, i_stop_det, i_hdr_exit,
    output o_sda_low, o_hdr_ddr_mode, o_ccc_valid, o_ccc_code,
           o_parity_err, o_done
  );
endinterface
`default_nettype wire

// File: rtl/enthdr_tgt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// enthdr_tgt : target responder that ACKs 7E+W and enters HDR-DDR on ENTHDR0
// Rev 1.0
// ---------------------------------------------------------------------------
module enthdr_tgt #(
  parameter logic [6:0] BCAST_ADDR  = 7'h7E,
  parameter logic [7:0] ENTHDR_CODE = 8'h20
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  enthdr_tgt_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ACK_WAIT = 3'd2,
    S_ACK      = 3'd3,
    S_CCC      = 3'd4,
    S_EVAL     = 3'd5,
    S_IGNORE   = 3'd6,
    S_HDR      = 3'd7
  } state_t;

  localparam logic [7:0] c_addr_w = {BCAST_ADDR, 1'b0};

  state_t     r_state,      w_state_nxt;
  logic [3:0] r_bit_cnt,    w_bit_cnt_nxt;
  logic [7:0] r_shift,      w_shift_nxt;
  logic       r_sda_low,    w_sda_low_nxt;
  logic       r_hdr_mode,   w_hdr_mode_nxt;
  logic [7:0] r_ccc_code,   w_ccc_code_nxt;
  logic       r_ccc_valid,  w_ccc_valid_nxt;
  logic       r_parity_err, w_parity_err_nxt;
  logic       r_done,       w_done_nxt;
  logic [7:0] w_sample;

  assign w_sample = {r_shift[6:0], bus.i_sda};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= 4'd0;
      r_shift      <= 8'd0;
      r_sda_low    <= 1'b0;
      r_hdr_mode   <= 1'b0;
      r_ccc_code   <= 8'd0;
      r_ccc_valid  <= 1'b0;
      r_parity_err <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_sda_low    <= w_sda_low_nxt;
      r_hdr_mode   <= w_hdr_mode_nxt;
      r_ccc_code   <= w_ccc_code_nxt;
      r_ccc_valid  <= w_ccc_valid_nxt;
      r_parity_err <= w_parity_err_nxt;
      r_done       <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_bit_cnt_nxt    = r_bit_cnt;
    w_shift_nxt      = r_shift;
    w_sda_low_nxt    = r_sda_low;
    w_hdr_mode_nxt   = r_hdr_mode;
    w_ccc_code_nxt   = r_ccc_code;
    w_ccc_valid_nxt  = 1'b0;
    w_parity_err_nxt = 1'b0;
    w_done_nxt       = 1'b0;

    if (!bus.i_engine_en) begin
      w_state_nxt    = S_IDLE;
      w_bit_cnt_nxt  = 4'd0;
      w_sda_low_nxt  = 1'b0;
      w_hdr_mode_nxt = 1'b0;
    end else if (r_state == S_IDLE) begin
      w_sda_low_nxt = 1'b0;
      if (bus.i_start_det) begin
        w_state_nxt   = S_ADDR;
        w_bit_cnt_nxt = 4'd0;
      end
    end else if (r_state == S_HDR) begin
      // SDR START/STOP framing is meaningless while the bus runs HDR-DDR
      w_hdr_mode_nxt = 1'b1;
      if (bus.i_hdr_exit) begin
        w_hdr_mode_nxt = 1'b0;
        w_state_nxt    = S_IDLE;
      end
    end else if (r_state == S_EVAL && r_hdr_mode) begin
      w_state_nxt = S_HDR;
    end else if (bus.i_stop_det) begin
      w_state_nxt   = S_IDLE;
      w_sda_low_nxt = 1'b0;
    end else if (bus.i_start_det) begin
      w_state_nxt   = S_ADDR;
      w_bit_cnt_nxt = 4'd0;
      w_sda_low_nxt = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (bus.i_scl_pos_edge) begin
            w_shift_nxt = w_sample;
            if (r_bit_cnt == 4'd7) begin
              w_bit_cnt_nxt = 4'd0;
              w_state_nxt   = (w_sample == c_addr_w) ? S_ACK_WAIT : S_IGNORE;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            end
          end
        end
        S_ACK_WAIT: begin
          if (bus.i_scl_neg_edge) begin
            w_sda_low_nxt = 1'b1;
            w_state_nxt   = S_ACK;
          end
        end
        S_ACK: begin
          if (bus.i_scl_neg_edge) begin
            w_sda_low_nxt = 1'b0;
            w_bit_cnt_nxt = 4'd0;
            w_state_nxt   = S_CCC;
          end
        end
        S_CCC: begin
          if (bus.i_scl_pos_edge) begin
            if (r_bit_cnt == 4'd8) begin
              // Result registers load with the T-bit sample so they show during EVAL
              w_bit_cnt_nxt = 4'd0;
              w_state_nxt   = S_EVAL;
              if (bus.i_sda != ~^r_shift) begin
                w_parity_err_nxt = 1'b1;
              end else if (r_shift == ENTHDR_CODE) begin
                w_hdr_mode_nxt = 1'b1;
                w_done_nxt     = 1'b1;
              end else begin
                w_ccc_code_nxt  = r_shift;
                w_ccc_valid_nxt = 1'b1;
              end
            end else begin
              w_shift_nxt   = w_sample;
              w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            end
          end
        end
        S_EVAL: begin
          w_state_nxt = S_IGNORE;
        end
        default: begin
          w_sda_low_nxt = 1'b0;
        end
      endcase
    end
  end

  assign bus.o_sda_low      = r_sda_low;
  assign bus.o_hdr_ddr_mode = r_hdr_mode;
  assign bus.o_ccc_valid    = r_ccc_valid;
  assign bus.o_ccc_code     = r_ccc_code;
  assign bus.o_parity_err   = r_parity_err;
  assign bus.o_done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_enthdr_tgt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_enthdr_tgt : randomized ENTHDR sequences checked against a transaction model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_enthdr_tgt;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sda_drv = 1'b1;

  enthdr_tgt_if bus ();

  // Open-drain wired-AND of controller drive and target pull-down
  assign bus.i_sda = sda_drv & ~bus.o_sda_low;

  enthdr_tgt #(
    .BCAST_ADDR  (7'h7E),
    .ENTHDR_CODE (8'h20)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_valid = 0;
  int n_perr = 0;
  logic [7:0] exp_code = 8'd0;

  always @(negedge clk) begin
    if (rst_n) begin
      n_done  += int'(bus.o_done);
      n_valid += int'(bus.o_ccc_valid);
      n_perr  += int'(bus.o_parity_err);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic clr_cnt();
    n_done = 0;
    n_valid = 0;
    n_perr = 0;
  endtask

  task automatic pulse_pos();
    bus.i_scl_pos_edge = 1'b1; tick(); bus.i_scl_pos_edge = 1'b0;
  endtask

  task automatic pulse_neg();
    bus.i_scl_neg_edge = 1'b1; tick(); bus.i_scl_neg_edge = 1'b0;
  endtask

  task automatic pulse_start();
    bus.i_start_det = 1'b1; tick(); bus.i_start_det = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.i_stop_det = 1'b1; tick(); bus.i_stop_det = 1'b0;
  endtask

  task automatic bit_hi(input logic b);
    sda_drv = b;
    gap($urandom_range(0, 2));
    pulse_pos();
    gap($urandom_range(0, 1));
  endtask

  task automatic bit_lo();
    pulse_neg();
    gap($urandom_range(0, 1));
  endtask

  task automatic send_addr(input logic [7:0] a, input logic ack);
    for (int i = 0; i < 8; i++) begin
      bit_hi(a[7-i]);
      if (i == 7) chk("ack_early", bus.o_sda_low, 0);
      bit_lo();
    end
    @(negedge clk);
    chk("ack_drive", bus.o_sda_low, ack);
    tick();
  endtask

  task automatic ack_bit(input logic ack);
    sda_drv = 1'b1;
    gap($urandom_range(0, 1));
    pulse_pos();
    @(negedge clk);
    chk("ack_hold", bus.o_sda_low, ack);
    chk("ack_sda", bus.i_sda, !ack);
    tick();
    pulse_neg();
    @(negedge clk);
    chk("ack_rel", bus.o_sda_low, 0);
    tick();
  endtask

  // Reference: 7E+W is ACKed; odd parity over the CCC byte decides error,
  // ENTHDR0 enters HDR, any other good code is reported and latched.
  task automatic run_txn(input logic [7:0] a, input logic [7:0] c, input logic t,
                         input int ccc_bits);
    logic ack, ok, e_done, e_valid, e_perr;
    ack     = (a == 8'hFC);
    ok      = (t == ~^c);
    e_perr  = ack && !ok;
    e_done  = ack && ok && (c == 8'h20);
    e_valid = ack && ok && (c != 8'h20);
    clr_cnt();
    pulse_start();
    gap($urandom_range(0, 2));
    send_addr(a, ack);
    ack_bit(ack);
    for (int i = 0; i < ccc_bits; i++) begin
      bit_hi(c[7-i]);
      bit_lo();
    end
    if (ccc_bits < 8) begin
      chk("abort_quiet", n_done + n_valid + n_perr, 0);
    end else begin
      sda_drv = t;
      gap($urandom_range(0, 2));
      pulse_pos();
      @(negedge clk);
      chk("lat_done", bus.o_done, e_done);
      chk("lat_valid", bus.o_ccc_valid, e_valid);
      chk("lat_perr", bus.o_parity_err, e_perr);
      tick();
      bit_lo();
      gap(3);
      if (e_valid) exp_code = c;
      chk("cnt_done", n_done, e_done);
      chk("cnt_valid", n_valid, e_valid);
      chk("cnt_perr", n_perr, e_perr);
      chk("ccc_code", bus.o_ccc_code, exp_code);
      chk("hdr_mode", bus.o_hdr_ddr_mode, e_done);
    end
  endtask

  task automatic finish_txn(input logic in_hdr);
    if (in_hdr) begin
      gap(2);
      pulse_start();
      pulse_stop();
      gap(1);
      chk("hdr_hold", bus.o_hdr_ddr_mode, 1);
      bus.i_hdr_exit = 1'b1; tick(); bus.i_hdr_exit = 1'b0;
      @(negedge clk);
      chk("hdr_exit", bus.o_hdr_ddr_mode, 0);
      tick();
    end else begin
      pulse_stop();
      gap(2);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] a, c;
    logic t;
    bus.i_engine_en    = 1'b1;
    bus.i_scl_pos_edge = 1'b0;
    bus.i_scl_neg_edge = 1'b0;
    bus.i_start_det    = 1'b0;
    bus.i_stop_det     = 1'b0;
    bus.i_hdr_exit     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sda_low", bus.o_sda_low, 0);
    chk("rst_hdr", bus.o_hdr_ddr_mode, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_valid", bus.o_ccc_valid, 0);
    chk("rst_perr", bus.o_parity_err, 0);
    chk("rst_code", bus.o_ccc_code, 0);
    rst_n = 1'b1;
    gap(2);

    run_txn(8'hFC, 8'h20, 1'b0, 8); finish_txn(1'b1);
    run_txn(8'hFC, 8'h20, 1'b1, 8); finish_txn(1'b0);
    run_txn(8'hA4, 8'h20, 1'b0, 8); finish_txn(1'b0);
    run_txn(8'hFC, 8'h06, 1'b1, 8); finish_txn(1'b0);

    // Repeated START after 4 CCC bits restarts framing
    run_txn(8'hFC, 8'h55, 1'b0, 4);
    run_txn(8'hFC, 8'h20, 1'b0, 8); finish_txn(1'b1);

    // STOP in the ACK high phase releases SDA; following bits are ignored
    clr_cnt();
    pulse_start();
    send_addr(8'hFC, 1'b1);
    sda_drv = 1'b1;
    pulse_pos();
    chk("stop_ack_pre", bus.o_sda_low, 1);
    pulse_stop();
    chk("stop_ack_rel", bus.o_sda_low, 0);
    bit_lo();
    for (int i = 0; i < 9; i++) begin
      bit_hi(1'($urandom));
      bit_lo();
    end
    gap(2);
    chk("stop_quiet", n_done + n_valid + n_perr, 0);
    chk("stop_hdr", bus.o_hdr_ddr_mode, 0);

    // Engine disable while in HDR
    run_txn(8'hFC, 8'h20, 1'b0, 8);
    clr_cnt();
    bus.i_engine_en = 1'b0;
    tick();
    chk("dis_hdr", bus.o_hdr_ddr_mode, 0);
    bus.i_engine_en = 1'b1;
    gap(2);
    chk("dis_quiet", n_done + n_valid + n_perr, 0);

    // Asynchronous reset while ACK is being driven
    pulse_start();
    send_addr(8'hFC, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_code = 8'd0;
    chk("arst_sda", bus.o_sda_low, 0);
    chk("arst_code", bus.o_ccc_code, exp_code);
    tick();
    rst_n = 1'b1;
    gap(2);

    for (int n = 0; n < 30; n++) begin
      a = ($urandom_range(0, 3) != 0) ? 8'hFC : 8'($urandom);
      c = ($urandom_range(0, 2) == 0) ? 8'h20 : 8'($urandom);
      t = ($urandom_range(0, 3) != 0) ? ~^c : ^c;
      run_txn(a, c, t, 8);
      finish_txn((a == 8'hFC) && (t == ~^c) && (c == 8'h20));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
